// File: rtl/tp_sound_mixer_if.sv
// tp_sound_mixer_if: channel levels, mask and volume in; mixed sample and strobe out
interface tp_sound_mixer_if;
  logic [47:0] ch;
  logic [5:0]  ch_mask;
  logic [3:0]  vol;
  logic [15:0] out;
  logic        out_valid;
  modport master (output ch, ch_mask, vol, input out, out_valid);
  modport slave  (input ch, ch_mask, vol, output out, out_valid);
endinterface

// File: rtl/tp_sound_mixer.sv
// tp_sound_mixer: six-channel PSG mixer with per-channel mute, master volume and saturation
module tp_sound_mixer #(
  parameter int DIV = 220
) (
  input  logic            clk,
  input  logic            reset,
  tp_sound_mixer_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_ACC, S_SCALE, S_OUT} state_t;
  state_t             r_state, w_next;
  logic [9:0]         r_cnt;
  logic [2:0]         r_idx;
  logic [47:0]        r_snap;
  logic [5:0]         r_mask;
  logic [3:0]         r_vol;
  logic signed [10:0] r_acc;
  logic signed [15:0] r_prod;
  logic [15:0]        r_out;
  logic               r_valid;
  logic               w_snap, w_acc, w_scale, w_load;
  logic [7:0]         w_byte, w_term;
  logic signed [15:0] w_mul;
  logic [15:0]        w_sat;
  // free-running sample period counter
  always_ff @(posedge clk)
    if (!reset) r_cnt <= '0;
    else r_cnt <= (r_cnt == 10'(DIV - 1)) ? '0 : r_cnt + 10'd1;
  // sequencer state register
  always_ff @(posedge clk)
    if (!reset) r_state <= S_IDLE;
    else r_state <= w_next;
  // sequencer next state: snapshot on period start, six accumulate steps, scale, emit
  always_comb
    w_next = r_state == S_IDLE  ? (r_cnt == 10'd0 ? S_ACC : S_IDLE) :
             r_state == S_ACC   ? (r_idx == 3'd5 ? S_SCALE : S_ACC) :
             r_state == S_SCALE ? S_OUT : S_IDLE;
  // per-state datapath controls and combinational arithmetic
  always_comb begin
    w_snap  = r_state == S_IDLE && r_cnt == 10'd0;
    w_acc   = r_state == S_ACC;
    w_scale = r_state == S_SCALE;
    w_load  = r_state == S_OUT;
    w_byte  = 8'(r_snap >> {r_idx, 3'b000});
    w_term  = r_mask[r_idx] ? {~w_byte[7], w_byte[6:0]} : 8'd0;
    w_mul   = $signed({{5{r_acc[10]}}, r_acc}) * $signed({12'd0, r_vol});
    w_sat   = (r_prod[15:13] == 3'b000 || r_prod[15:13] == 3'b111) ? {r_prod[13:0], 2'b00} :
              (r_prod[15] ? 16'h8000 : 16'h7FFF);
  end
  // datapath registers: snapshot, signed accumulate, volume scale, saturated output
  always_ff @(posedge clk)
    if (!reset) begin
      r_idx   <= '0;
      r_acc   <= '0;
      r_prod  <= '0;
      r_snap  <= '0;
      r_mask  <= '0;
      r_vol   <= '0;
      r_out   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_load;
      if (w_snap) begin
        r_snap <= bus.ch;
        r_mask <= bus.ch_mask;
        r_vol  <= bus.vol;
        r_acc  <= '0;
        r_idx  <= '0;
      end
      if (w_acc) begin
        r_acc <= r_acc + {{3{w_term[7]}}, w_term};
        r_idx <= r_idx == 3'd5 ? r_idx : r_idx + 3'd1;
      end
      if (w_scale) r_prod <= w_mul;
      if (w_load) r_out <= w_sat;
    end
  assign bus.out       = r_out;
  assign bus.out_valid = r_valid;
endmodule

// File: doc/tp_sound_mixer.md
# tp_sound_mixer

Time-multiplexed mixer that sits directly upstream of the Time Pilot low-pass filter chain. It snapshots the six AY-3-8910 channel levels (two PSGs × three channels) once per sample period, sums them in signed form with per-channel muting, and applies a master volume with saturation. It produces the signed 16-bit sample that the filters consume. The output is held between updates, and a one-cycle strobe marks each new sample.

## Interface

Parameters:
- DIV, default 220: sample period in clk cycles (49.152 MHz / 220 = 223418 Hz, matching the filter sample rate). Legal range 10..1023.

Ports:
- clk  input  1  system clock, 49.152 MHz
- reset  input  1  synchronous, active-low; sampled on clk rising edge; 0 = reset
- ch  input  48  six unsigned 8-bit channel levels; channel k is ch[8k+7:8k]; k=0..2 is PSG0 A/B/C, k=3..5 is PSG1 A/B/C
- ch_mask  input  6  bit k = 1 enables channel k; 0 mutes it
- vol  input  4  master volume, 0..15
- out  output  16  signed mixed sample, two's complement
- out_valid  output  1  one-cycle pulse when out takes a new value

## Operation

- Period counter cnt counts 0..DIV-1 and wraps to 0. It is free-running and independent of state.
- Sequencer FSM states:
  - IDLE: waits for cnt==0.
  - ACC: six cycles, with index idx running 0..5.
  - SCALE: one cycle.
  - OUT: one cycle.
- IDLE, at an edge with cnt==0:
  - snap ← ch, mask_r ← ch_mask, vol_r ← vol.
  - acc ← 0, idx ← 0, go to ACC.
  - All inputs are sampled only at this edge. Input changes during a conversion have no effect on it.
- ACC, at each edge:
  - acc ← acc + (mask_r[idx] ? snap[idx] − 128 : 0).
  - Each term is signed, −128..+127; acc is signed 11-bit, range −768..+762.
  - When idx==5, go to SCALE; otherwise idx ← idx+1.
- SCALE: prod ← acc × vol_r (signed 16-bit, range −11520..+11430), then go to OUT.
- OUT:
  - out ← sat16(prod × 4). Saturate to +32767 if above, −32768 if below; no wrap permitted.
  - out_valid ← 1 for this one cycle only, then go to IDLE.
- out holds its value in every state other than OUT.
- A muted channel contributes exactly 0, so an all-muted mix is silence (out = 0).
- vol_r = 0 forces out = 0.
- Reset (reset==0 at an edge), from any state:
  - cnt ← 0, state ← IDLE, idx ← 0, acc ← 0, prod ← 0, snap ← 0.
  - out ← 0, out_valid ← 0.
  - An interrupted conversion is discarded: no out update and no out_valid pulse.

## Timing

- Reset values: out = 0, out_valid = 0.
- The first snapshot occurs at the first edge after reset deasserts, because cnt==0 at that edge.
- Latency:
  - Snapshot edge E0; accumulate edges E1..E6; SCALE edge E7; out and out_valid update at E8.
  - out_valid is high for exactly the one cycle following E8.
  - Snapshot-to-output latency is therefore 8 clk cycles.
- Throughput: one sample per DIV cycles. Successive out_valid pulses are exactly DIV cycles apart.
- The FSM is busy 8 cycles per period. DIV ≥ 10 guarantees it is in IDLE before cnt next returns to 0.
- cnt wrap and conversion completion never coincide for legal DIV, so no simultaneous-event arbitration is needed.
- Reset asserted on the same edge as cnt==0: reset wins and no snapshot is taken.

## Test plan

- Reset then release, ch all 8'h80, mask 6'h3F, vol 8 -> out = 0 throughout; first out_valid exactly 8 cycles after the first post-reset edge; subsequent out_valid pulses every 220 cycles.
- ch all 8'hFF, mask 6'h3F, vol 8 -> out = 24384 (762×8×4); ch all 8'h00, vol 8 -> out = −24576.
- ch all 8'hFF, vol 15 -> out = 32767 (saturated from 45720); ch all 8'h00, vol 15 -> out = −32768 (saturated from −46080).
- ch all 8'hFF, vol 8, mask 6'b000001 -> out = 4064 (127×32); mask 6'h00 -> out = 0; vol 0 with mask 6'h3F -> out = 0.
- Change ch and vol 3 cycles after a snapshot edge -> out for that period reflects the old values; the next period reflects the new ones.
- Assert reset 4 cycles after a snapshot edge, hold 2 cycles, release -> no out_valid for the aborted conversion; out = 0; the next out_valid comes 8 cycles after release.
